// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response encodings and the write-slave state
// enum, imported by both the read and write slaves.
package axi4_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_ACCEPT   = 2'd0,
      ST_REQUEST  = 2'd1,
      ST_RESPONSE = 2'd2
   } write_state_t;

endpackage : axi4_lite_pkg

// File: rtl/axi4_lite_slave_write_dec.sv
// AXI4-Lite write slave: captures AW and W independently, issues one backend
// write request and returns the backend status on B. Optional backend timeout
// is enabled by defining AXI4_LITE_WRITE_TIMEOUT_EN.
module axi4_lite_slave_write_dec
   import axi4_lite_pkg::*;
#(
   parameter int addr_width     = 7,
   parameter int data_width     = 32,
   parameter int timeout_cycles = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   // register-file backend
   output logic                      write_req,
   output logic [addr_width-1:0]     write_addr,
   output logic [data_width-1:0]     write_data,
   output logic [data_width/8-1:0]   write_strb,
   input  logic                      write_ready,
   input  logic                      write_response,
   // AXI write address channel
   input  logic [addr_width-1:0]     s_axi_awaddr,
   input  logic [2:0]                s_axi_awprot,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   // AXI write data channel
   input  logic [data_width-1:0]     s_axi_wdata,
   input  logic [data_width/8-1:0]   s_axi_wstrb,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   // AXI write response channel
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready
);

   localparam int STRB_W = data_width / 8;

   if ((data_width % 8) != 0 || data_width < 8) begin : g_bad_data_width
      $error("data_width must be a positive multiple of 8");
   end
   if (timeout_cycles < 1) begin : g_bad_timeout
      $error("timeout_cycles must be at least 1");
   end

   write_state_t              r_state,        w_state_nxt;
   logic                      r_awready,      w_awready_nxt;
   logic                      r_wready,       w_wready_nxt;
   logic                      r_aw_done,      w_aw_done_nxt;
   logic                      r_w_done,       w_w_done_nxt;
   logic                      r_write_req,    w_write_req_nxt;
   logic [addr_width-1:0]     r_write_addr,   w_write_addr_nxt;
   logic [data_width-1:0]     r_write_data,   w_write_data_nxt;
   logic [STRB_W-1:0]         r_write_strb,   w_write_strb_nxt;
   logic                      r_bvalid,       w_bvalid_nxt;
   logic [1:0]                r_bresp,        w_bresp_nxt;

   logic                      w_aw_hs;
   logic                      w_w_hs;
   logic                      w_aw_have;
   logic                      w_w_have;
   logic [STRB_W-1:0]         w_strb_now;
   logic                      w_unused_awprot;

   // Protection bits carry no meaning for this register space.
   assign w_unused_awprot = ^s_axi_awprot;

`ifdef AXI4_LITE_WRITE_TIMEOUT_EN
   localparam int CNT_W = $clog2(timeout_cycles + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_cycles - 1);

   logic [CNT_W-1:0]          r_timeout_cnt,  w_timeout_cnt_nxt;
`endif

   // Ready outputs are only ever high in ST_ACCEPT, so these are the handshakes.
   assign w_aw_hs    = r_awready & s_axi_awvalid;
   assign w_w_hs     = r_wready  & s_axi_wvalid;
   assign w_aw_have  = r_aw_done | w_aw_hs;
   assign w_w_have   = r_w_done  | w_w_hs;
   assign w_strb_now = w_w_hs ? s_axi_wstrb : r_write_strb;

   // NOTE: every next-value is given a default before the case statement so no
   // path leaves a combinational output unassigned and infers a latch.
   always_comb begin
      w_state_nxt      = r_state;
      w_awready_nxt    = r_awready;
      w_wready_nxt     = r_wready;
      w_aw_done_nxt    = r_aw_done;
      w_w_done_nxt     = r_w_done;
      w_write_req_nxt  = r_write_req;
      w_write_addr_nxt = r_write_addr;
      w_write_data_nxt = r_write_data;
      w_write_strb_nxt = r_write_strb;
      w_bvalid_nxt     = r_bvalid;
      w_bresp_nxt      = r_bresp;
`ifdef AXI4_LITE_WRITE_TIMEOUT_EN
      w_timeout_cnt_nxt = '0;
`endif

      case (r_state)
         ST_ACCEPT: begin
            if (w_aw_hs) begin
               w_write_addr_nxt = s_axi_awaddr;
               w_aw_done_nxt    = 1'b1;
               w_awready_nxt    = 1'b0;
            end else begin
               w_awready_nxt    = ~r_aw_done;
            end
            if (w_w_hs) begin
               w_write_data_nxt = s_axi_wdata;
               w_write_strb_nxt = s_axi_wstrb;
               w_w_done_nxt     = 1'b1;
               w_wready_nxt     = 1'b0;
            end else begin
               w_wready_nxt     = ~r_w_done;
            end
            if (w_aw_have && w_w_have) begin
               w_aw_done_nxt = 1'b0;
               w_w_done_nxt  = 1'b0;
               w_awready_nxt = 1'b0;
               w_wready_nxt  = 1'b0;
               // An all-zero strobe writes nothing, so the backend is not bothered.
               if (w_strb_now == '0) begin
                  w_state_nxt     = ST_RESPONSE;
                  w_bresp_nxt     = RESP_OKAY;
               end else begin
                  w_state_nxt     = ST_REQUEST;
                  w_write_req_nxt = 1'b1;
               end
            end
         end

         ST_REQUEST: begin
            if (write_ready) begin
               w_write_req_nxt = 1'b0;
               w_bvalid_nxt    = 1'b1;
               w_bresp_nxt     = {~write_response, 1'b0};
               w_state_nxt     = ST_RESPONSE;
`ifdef AXI4_LITE_WRITE_TIMEOUT_EN
            end else if (r_timeout_cnt == CNT_LAST) begin
               w_write_req_nxt = 1'b0;
               w_bvalid_nxt    = 1'b1;
               w_bresp_nxt     = RESP_SLVERR;
               w_state_nxt     = ST_RESPONSE;
            end else begin
               w_timeout_cnt_nxt = r_timeout_cnt + 1'b1;
`endif
            end
         end

         ST_RESPONSE: begin
            // Bypassed writes arrive with bvalid low and raise it one cycle later.
            if (!r_bvalid) begin
               w_bvalid_nxt = 1'b1;
            end else if (s_axi_bready) begin
               w_bvalid_nxt  = 1'b0;
               w_awready_nxt = 1'b1;
               w_wready_nxt  = 1'b1;
               w_state_nxt   = ST_ACCEPT;
            end
         end

         default: begin
            w_state_nxt = ST_ACCEPT;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_ACCEPT;
         r_awready     <= 1'b0;
         r_wready      <= 1'b0;
         r_aw_done     <= 1'b0;
         r_w_done      <= 1'b0;
         r_write_req   <= 1'b0;
         r_write_addr  <= '0;
         r_write_data  <= '0;
         r_write_strb  <= '0;
         r_bvalid      <= 1'b0;
         r_bresp       <= RESP_OKAY;
`ifdef AXI4_LITE_WRITE_TIMEOUT_EN
         r_timeout_cnt <= '0;
`endif
      end else begin
         r_state       <= w_state_nxt;
         r_awready     <= w_awready_nxt;
         r_wready      <= w_wready_nxt;
         r_aw_done     <= w_aw_done_nxt;
         r_w_done      <= w_w_done_nxt;
         r_write_req   <= w_write_req_nxt;
         r_write_addr  <= w_write_addr_nxt;
         r_write_data  <= w_write_data_nxt;
         r_write_strb  <= w_write_strb_nxt;
         r_bvalid      <= w_bvalid_nxt;
         r_bresp       <= w_bresp_nxt;
`ifdef AXI4_LITE_WRITE_TIMEOUT_EN
         r_timeout_cnt <= w_timeout_cnt_nxt;
`endif
      end
   end

   assign write_req     = r_write_req;
   assign write_addr    = r_write_addr;
   assign write_data    = r_write_data;
   assign write_strb    = r_write_strb;
   assign s_axi_awready = r_awready;
   assign s_axi_wready  = r_wready;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = r_bresp;

endmodule : axi4_lite_slave_write_dec

// File: tb/tb_axi4_lite_slave_write_dec.sv
// Scoreboard bench for axi4_lite_slave_write_dec: directed transactions push
// expected backend requests and B responses; a negedge monitor pops and compares.
module tb_axi4_lite_slave_write_dec;

   localparam int AW = 7;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
   } req_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          write_req;
   logic [AW-1:0] write_addr;
   logic [DW-1:0] write_data;
   logic [SW-1:0] write_strb;
   logic          write_ready;
   logic          write_response;
   logic [AW-1:0] s_axi_awaddr;
   logic [2:0]    s_axi_awprot;
   logic          s_axi_awvalid;
   logic          s_axi_awready;
   logic [DW-1:0] s_axi_wdata;
   logic [SW-1:0] s_axi_wstrb;
   logic          s_axi_wvalid;
   logic          s_axi_wready;
   logic [1:0]    s_axi_bresp;
   logic          s_axi_bvalid;
   logic          s_axi_bready;

   int n_checks = 0;
   int n_errors = 0;

   req_t       exp_req_q[$];
   logic [1:0] exp_resp_q[$];

   axi4_lite_slave_write_dec #(
      .addr_width     (AW),
      .data_width     (DW),
      .timeout_cycles (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .write_req      (write_req),
      .write_addr     (write_addr),
      .write_data     (write_data),
      .write_strb     (write_strb),
      .write_ready    (write_ready),
      .write_response (write_response),
      .s_axi_awaddr   (s_axi_awaddr),
      .s_axi_awprot   (s_axi_awprot),
      .s_axi_awvalid  (s_axi_awvalid),
      .s_axi_awready  (s_axi_awready),
      .s_axi_wdata    (s_axi_wdata),
      .s_axi_wstrb    (s_axi_wstrb),
      .s_axi_wvalid   (s_axi_wvalid),
      .s_axi_wready   (s_axi_wready),
      .s_axi_bresp    (s_axi_bresp),
      .s_axi_bvalid   (s_axi_bvalid),
      .s_axi_bready   (s_axi_bready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_awready"}, s_axi_awready, 0);
      check({tag, "_wready"},  s_axi_wready,  0);
      check({tag, "_req"},     write_req,     0);
      check({tag, "_bvalid"},  s_axi_bvalid,  0);
      check({tag, "_bresp"},   s_axi_bresp,   0);
      check({tag, "_addr"},    write_addr,    0);
      check({tag, "_data"},    write_data,    0);
      check({tag, "_strb"},    write_strb,    0);
   endtask

   task automatic drive_aw(input logic [AW-1:0] a);
      s_axi_awaddr  = a;
      s_axi_awvalid = 1'b1;
   endtask

   task automatic drive_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
      s_axi_wdata  = d;
      s_axi_wstrb  = s;
      s_axi_wvalid = 1'b1;
   endtask

   // Monitor: compares backend requests and B responses against the queues.
   always @(negedge clk) begin
      req_t       r;
      logic [1:0] b;
      if (!rst) begin
         if (write_req && write_ready) begin
            if (exp_req_q.size() == 0) begin
               check("unexpected_req", 1, 0);
            end else begin
               r = exp_req_q.pop_front();
               check("req_addr", write_addr, r.addr);
               check("req_data", write_data, r.data);
               check("req_strb", write_strb, r.strb);
            end
         end
         if (s_axi_bvalid && s_axi_bready) begin
            if (exp_resp_q.size() == 0) begin
               check("unexpected_b", 1, 0);
            end else begin
               b = exp_resp_q.pop_front();
               check("bresp", s_axi_bresp, b);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      write_ready = 1'b0; write_response = 1'b0;
      s_axi_awaddr = '0; s_axi_awprot = 3'b0; s_axi_awvalid = 1'b0;
      s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b0;

      // Reset state and first cycle out of reset
      step(); step();
      check_reset_outputs("rst");
      rst = 1'b0;
      step();
      check("post_rst_awready", s_axi_awready, 1);
      check("post_rst_wready",  s_axi_wready,  1);

      // T1: AW and W together, immediate backend and bready
      drive_aw(7'h14); drive_w(32'hDEADBEEF, 4'hF);
      exp_req_q.push_back('{7'h14, 32'hDEADBEEF, 4'hF});
      exp_resp_q.push_back(2'b00);
      step();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      check("t1_req_high", write_req, 1);
      check("t1_awready_low", s_axi_awready, 0);
      check("t1_wready_low", s_axi_wready, 0);
      write_ready = 1'b1; write_response = 1'b1; s_axi_bready = 1'b1;
      step();
      write_ready = 1'b0;
      check("t1_req_one_cycle", write_req, 0);
      check("t1_bvalid", s_axi_bvalid, 1);
      check("t1_bresp_okay", s_axi_bresp, 2'b00);
      step();
      s_axi_bready = 1'b0;
      check("t1_bvalid_clear", s_axi_bvalid, 0);
      check("t1_awready_back", s_axi_awready, 1);
      check("t1_wready_back", s_axi_wready, 1);

      // T2: W two cycles before AW
      drive_w(32'h12345678, 4'h3);
      exp_req_q.push_back('{7'h08, 32'h12345678, 4'h3});
      exp_resp_q.push_back(2'b00);
      step();
      s_axi_wvalid = 1'b0;
      check("t2_wready_low", s_axi_wready, 0);
      check("t2_awready_high", s_axi_awready, 1);
      check("t2_no_req_early", write_req, 0);
      step();
      check("t2_wready_still_low", s_axi_wready, 0);
      drive_aw(7'h08);
      step();
      s_axi_awvalid = 1'b0;
      check("t2_req_high", write_req, 1);
      check("t2_addr", write_addr, 7'h08);
      step(); step();
      check("t2_req_held", write_req, 1);
      write_ready = 1'b1; write_response = 1'b1;
      step();
      write_ready = 1'b0;
      check("t2_bvalid", s_axi_bvalid, 1);
      s_axi_bready = 1'b1;
      step();
      s_axi_bready = 1'b0;

      // T3: SLVERR, bready held off 5 cycles while new AW/W are offered
      drive_aw(7'h7F); drive_w(32'h0BADF00D, 4'h5);
      exp_req_q.push_back('{7'h7F, 32'h0BADF00D, 4'h5});
      exp_resp_q.push_back(2'b10);
      step();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      write_ready = 1'b1; write_response = 1'b0;
      step();
      write_ready = 1'b0;
      drive_aw(7'h22); drive_w(32'h11111111, 4'hF);
      for (int i = 0; i < 5; i++) begin
         check("t3_bvalid_held", s_axi_bvalid, 1);
         check("t3_bresp_slverr", s_axi_bresp, 2'b10);
         check("t3_awready_blocked", s_axi_awready, 0);
         step();
      end
      check("t3_addr_kept", write_addr, 7'h7F);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b1;
      step();
      s_axi_bready = 1'b0;
      check("t3_awready_back", s_axi_awready, 1);

      // T4: zero-strobe bypass
      drive_aw(7'h30); drive_w(32'hCAFEF00D, 4'h0);
      exp_resp_q.push_back(2'b00);
      step();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      check("t4_no_req", write_req, 0);
      check("t4_bvalid_not_yet", s_axi_bvalid, 0);
      check("t4_strb_zero", write_strb, 0);
      step();
      check("t4_no_req_late", write_req, 0);
      check("t4_bvalid", s_axi_bvalid, 1);
      check("t4_bresp_okay", s_axi_bresp, 2'b00);
      s_axi_bready = 1'b1;
      step();
      s_axi_bready = 1'b0;

`ifdef AXI4_LITE_WRITE_TIMEOUT_EN
      // T5a: backend never answers -> SLVERR after 8 request cycles
      drive_aw(7'h40); drive_w(32'hA0A0A0A0, 4'hF);
      exp_resp_q.push_back(2'b10);
      step();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("t5_req_held", write_req, 1);
         step();
      end
      check("t5_req_dropped", write_req, 0);
      check("t5_bvalid", s_axi_bvalid, 1);
      check("t5_bresp_slverr", s_axi_bresp, 2'b10);
      s_axi_bready = 1'b1;
      step();
      s_axi_bready = 1'b0;

      // T5b: write_ready on the expiry cycle -> backend status wins
      drive_aw(7'h41); drive_w(32'hB0B0B0B0, 4'h1);
      exp_req_q.push_back('{7'h41, 32'hB0B0B0B0, 4'h1});
      exp_resp_q.push_back(2'b00);
      step();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         check("t5b_req_held", write_req, 1);
         step();
      end
      write_ready = 1'b1; write_response = 1'b1;
      step();
      write_ready = 1'b0;
      check("t5b_bvalid", s_axi_bvalid, 1);
      check("t5b_bresp_okay", s_axi_bresp, 2'b00);
      s_axi_bready = 1'b1;
      step();
      s_axi_bready = 1'b0;
`endif

      // T6: reset in ST_REQUEST, then a normal transaction
      drive_aw(7'h66); drive_w(32'h77777777, 4'hF);
      step();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      check("t6_req_high", write_req, 1);
      rst = 1'b1;
      step();
      check_reset_outputs("t6_rst");
      rst = 1'b0;
      step();
      check("t6_awready", s_axi_awready, 1);
      drive_aw(7'h55); drive_w(32'hA5A50F0F, 4'hC);
      exp_req_q.push_back('{7'h55, 32'hA5A50F0F, 4'hC});
      exp_resp_q.push_back(2'b00);
      step();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      check("t6_req_after", write_req, 1);
      write_ready = 1'b1; write_response = 1'b1; s_axi_bready = 1'b1;
      step();
      write_ready = 1'b0;
      check("t6_bvalid", s_axi_bvalid, 1);
      step();
      s_axi_bready = 1'b0;
      check("t6_done", s_axi_bvalid, 0);

      step();
      check("req_queue_empty", exp_req_q.size(), 0);
      check("resp_queue_empty", exp_resp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_axi4_lite_slave_write_dec
